// File: rtl/ex3_conv_scheduler_if.sv
// Word-level request/result bundle for ex3_conv_scheduler.
// The master side is the requesters plus the result consumer; the slave side is the scheduler.
interface ex3_conv_scheduler_if #(
    parameter int unsigned W = 5
);
    logic [1:0]     req_valid;
    logic [2*W-1:0] req_word;
    logic [1:0]     req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           res_id;
    logic           res_err;

    modport master (
        output req_valid, req_word, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err
    );

    modport slave (
        input  req_valid, req_word, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err
    );
endinterface

// File: rtl/ex3_conv_scheduler.sv
// Round-robin scheduler sharing one bit-serial Ex-3-to-binary converter between two requesters.
// Optional ERR_CHECK_EN: words below 3 bypass the converter and return res_err=1, res_data=0.
module ex3_conv_scheduler #(
    parameter int unsigned W        = 5,
    parameter int unsigned CONV_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    ex3_conv_scheduler_if.slave bus,
    output logic                conv_rst,
    output logic                conv_inp,
    input  logic                conv_outp
);
    localparam int unsigned CntW = $clog2(W + CONV_LAT + 1);

    typedef enum logic [2:0] {StIdle, StCrst, StShift, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] bit_idx;
    logic [W-1:0]    word_q, word_d;
    logic [W-1:0]    res_q, res_d;
    logic            id_q, id_d;
    logic            ptr_q, ptr_d;
    logic            err_q, err_d;
    logic            crst_q, crst_d;
    logic [1:0]      grant;
    logic            gnt_id;
    logic            accept;
    logic [W-1:0]    gnt_word;

    // Grant only in IDLE and never while reset is asserted, even if requests are held.
    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (state_q == StIdle && rst) begin
            if (bus.req_valid[ptr_q]) begin
                gnt_id        = ptr_q;
                grant[ptr_q]  = 1'b1;
            end else if (bus.req_valid[!ptr_q]) begin
                gnt_id        = !ptr_q;
                grant[!ptr_q] = 1'b1;
            end
        end
    end

    assign accept   = |grant;
    assign gnt_word = gnt_id ? bus.req_word[2*W-1:W] : bus.req_word[W-1:0];
    assign bit_idx  = cnt_q - CntW'(CONV_LAT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        res_d    = res_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        conv_inp = 1'b0;

        // Converter output lags the input by CONV_LAT cycles, so capture trails the shift count.
        if ((state_q == StShift || state_q == StDrain) && cnt_q >= CntW'(CONV_LAT)) begin
            res_d[bit_idx] = conv_outp;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    word_d  = gnt_word;
                    id_d    = gnt_id;
                    ptr_d   = !gnt_id;
                    res_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StCrst;
`ifdef ERR_CHECK_EN
                    if (gnt_word < W'(3)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
`endif
                end
            end
            StCrst: begin
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                conv_inp = word_q[cnt_q];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(W - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(W + CONV_LAT - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Rejected words keep the converter parked in reset for the whole result phase.
        crst_d = (state_d == StCrst) || ((state_d == StDone) && err_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
            res_q   <= '0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
            err_q   <= 1'b0;
            crst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            res_q   <= res_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            crst_q  <= crst_d;
        end
    end

    assign conv_rst      = crst_q;
    assign bus.req_ready = grant;
    assign bus.res_valid = (state_q == StDone);
    assign bus.res_data  = res_q;
    assign bus.res_id    = id_q;
    assign bus.res_err   = err_q;
endmodule

// File: tb/tb_ex3_conv_scheduler.sv
// Self-checking bench for ex3_conv_scheduler with a behavioural serial subtract-3 converter.
// Expected results come from plain arithmetic on the requested word and a round-robin pointer.
module tb_ex3_conv_scheduler;
    logic clk;
    logic rst;
    logic conv_rst;
    logic conv_inp;
    logic conv_outp;

    int   total;
    int   bad;
    logic ptr;

    logic [1:0] rv;
    logic [4:0] rw0;
    logic [4:0] rw1;
    logic       seen_valid;

    ex3_conv_scheduler_if #(.W(5)) bus ();

    ex3_conv_scheduler #(
        .W       (5),
        .CONV_LAT(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .conv_rst (conv_rst),
        .conv_inp (conv_inp),
        .conv_outp(conv_outp)
    );

    // Converter stand-in: LSB-first subtraction of 00011, one registered output bit per input bit.
    logic [2:0] cv_k;
    logic       cv_borrow;
    logic       cv_out;
    logic       cv_sub;
    logic       cv_diff;
    logic       cv_bnext;

    assign cv_sub    = (cv_k < 3'd2);
    assign cv_diff   = conv_inp ^ cv_sub ^ cv_borrow;
    assign cv_bnext  = (!conv_inp && (cv_sub || cv_borrow)) || (cv_sub && cv_borrow);
    assign conv_outp = cv_out;

    always @(posedge clk) begin
        if (conv_rst) begin
            cv_k      <= 3'd0;
            cv_borrow <= 1'b0;
            cv_out    <= 1'b0;
        end else begin
            if (cv_k != 3'd7) cv_k <= cv_k + 3'd1;
            cv_borrow <= cv_bnext;
            cv_out    <= cv_diff;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] ref_data(input logic [4:0] w);
`ifdef ERR_CHECK_EN
        if (w < 5'd3) return 5'd0;
`endif
        return w - 5'd3;
    endfunction

    function automatic logic ref_err(input logic [4:0] w);
`ifdef ERR_CHECK_EN
        return (w < 5'd3);
`else
        return (w == 5'd31) && (w != 5'd31);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; runs one job to completion including handshake.
    task automatic serve(input string tag, input logic [1:0] valid, input logic [4:0] w0,
                         input logic [4:0] w1, input int stall);
        logic       eid;
        logic [1:0] eg;
        logic [4:0] w;
        logic [5:0] seq;
        logic       crst_first;
        int         n;
        int         elat;
        bus.req_valid = valid;
        bus.req_word  = {w1, w0};
        bus.res_ready = 1'b0;
        #1;
        eid = valid[ptr] ? ptr : !ptr;
        eg  = eid ? 2'b10 : 2'b01;
        w   = eid ? w1 : w0;
        check({tag, ":grant"}, 32'(bus.req_ready), 32'(eg));
        ptr = !eid;
        elat = ref_err(w) ? 1 : 8;
        n = 0;
        seq = '0;
        crst_first = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n <= 6) seq = {conv_inp, seq[5:1]};
            if (n == 1) crst_first = conv_rst;
            if (bus.res_valid) break;
        end
        check({tag, ":latency"}, 32'(n), 32'(elat));
        check({tag, ":conv_rst_first"}, 32'(crst_first), 32'd1);
        if (!ref_err(w)) check({tag, ":serial_in"}, 32'(seq), 32'({w, 1'b0}));
        check({tag, ":data"}, 32'(bus.res_data), 32'(ref_data(w)));
        check({tag, ":id"}, 32'(bus.res_id), 32'(eid));
        check({tag, ":err"}, 32'(bus.res_err), 32'(ref_err(w)));
        check({tag, ":busy_ready"}, 32'(bus.req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, ":stall_valid"}, 32'(bus.res_valid), 32'd1);
            check({tag, ":stall_data"}, 32'(bus.res_data), 32'(ref_data(w)));
            check({tag, ":stall_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, ":valid_drop"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ptr   = 1'b0;
        rst   = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_word  = 10'h3ff;
        bus.res_ready = 1'b0;

        // Reset state, with requests held to confirm no grant leaks through.
        repeat (2) @(negedge clk);
        check("rst:req_ready", 32'(bus.req_ready), 32'd0);
        check("rst:res_valid", 32'(bus.res_valid), 32'd0);
        check("rst:res_data", 32'(bus.res_data), 32'd0);
        check("rst:res_id", 32'(bus.res_id), 32'd0);
        check("rst:res_err", 32'(bus.res_err), 32'd0);
        check("rst:conv_rst", 32'(conv_rst), 32'd1);
        check("rst:conv_inp", 32'(conv_inp), 32'd0);
        bus.req_valid = 2'b00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle:conv_rst", 32'(conv_rst), 32'd0);

        serve("single", 2'b01, 5'b01000, 5'b00000, 0);
        bus.req_valid = 2'b00;
        serve("all_ones", 2'b10, 5'b00000, 5'b11111, 0);
        serve("backpressure", 2'b11, 5'b00000, 5'b01100, 5);
        bus.req_valid = 2'b00;
        serve("low_code", 2'b10, 5'b00000, 5'b00010, 0);
        bus.req_valid = 2'b00;

        // Reset in the middle of the shift phase discards the job.
        bus.req_valid = 2'b01;
        bus.req_word  = {5'd0, 5'b10101};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst:req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst:res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst:res_data", 32'(bus.res_data), 32'd0);
        check("midrst:res_id", 32'(bus.res_id), 32'd0);
        check("midrst:res_err", 32'(bus.res_err), 32'd0);
        check("midrst:conv_rst", 32'(conv_rst), 32'd1);
        check("midrst:conv_inp", 32'(conv_inp), 32'd0);
        ptr = 1'b0;
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | bus.res_valid;
        end
        check("midrst:no_result", 32'(seen_valid), 32'd0);

        // Both requesters held for four jobs: grants must alternate starting from req0.
        for (int j = 0; j < 4; j++) begin
            serve("contention", 2'b11, 5'b10010, 5'b00111, 0);
        end
        bus.req_valid = 2'b00;

        for (int j = 0; j < 8; j++) begin
            rv  = 2'($urandom_range(1, 3));
            rw0 = 5'($urandom);
            rw1 = 5'($urandom);
            serve("random", rv, rw0, rw1, int'($urandom_range(0, 2)));
        end
        bus.req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
